// File: rtl/mips_result_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mips_result_serializer
// Description : Buffers MIPS execute result bundles (fail flag plus four
//               32-bit read-outs) in a small FIFO and serializes each one as
//               a byte frame over a valid/ready handshake.
//               OK frame   : HDR_OK,   seq, d1[31:24] ... d4[7:0]  (18 bytes)
//               Fail frame : HDR_FAIL, seq                         (2 bytes)
// Ports       : clk, rst (async, active-high)
//               in_valid/in_fail/in_data_1..4 : result bundle strobe + payload
//               tx_valid/tx_ready/tx_data/tx_last : byte stream handshake
//               busy     : frame in progress or FIFO non-empty
//               overflow : sticky, a bundle was dropped on a full FIFO
//               drop_cnt : dropped bundle count, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module mips_result_serializer #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [7:0]  HDR_OK     = 8'hA5,
   parameter logic [7:0]  HDR_FAIL   = 8'hEE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_fail,
   input  logic [31:0] in_data_1,
   input  logic [31:0] in_data_2,
   input  logic [31:0] in_data_3,
   input  logic [31:0] in_data_4,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_last,
   output logic        busy,
   output logic        overflow,
   output logic [7:0]  drop_cnt
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_SEQ  = 2'd2,
      S_BODY = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [128:0]         r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;

   logic [127:0]         r_shift;
   logic                 r_fail;
   logic [7:0]           r_seq;
   logic [3:0]           r_cnt;
   logic                 r_overflow;
   logic [7:0]           r_drop_cnt;

   logic                 w_pop;
   logic                 w_full;
   logic                 w_push;
   logic                 w_drop;
   logic                 w_tx_valid;
   logic [7:0]           w_tx_data;
   logic                 w_tx_last;
   logic                 w_accept;
   logic                 w_frame_done;

   // The FSM only pops from IDLE, which is what guarantees one bubble cycle
   // between consecutive frames.
   assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_full       = (r_count == c_CNT_W'(FIFO_DEPTH)) && !w_pop;
   assign w_push       = in_valid && !w_full;
   assign w_drop       = in_valid && w_full;
   assign w_accept     = w_tx_valid && tx_ready;
   assign w_frame_done = w_accept && w_tx_last;

   // ---------------------------------------------------------------------
   // FIFO storage (payload only, no reset needed)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_fail, in_data_1, in_data_2, in_data_3, in_data_4};
      end
   end

   // ---------------------------------------------------------------------
   // FIFO control, drop accounting
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM state register and frame datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_fail  <= 1'b0;
         r_seq   <= 8'd0;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) begin
            {r_fail, r_shift} <= r_mem[r_rd_ptr];
         end
         if (r_state == S_SEQ && w_accept) begin
            r_cnt <= 4'd15;
         end
         if (r_state == S_BODY && w_accept) begin
            r_shift <= {r_shift[119:0], 8'h00};
            r_cnt   <= r_cnt - 4'd1;
         end
         // seq advances once per completed frame and wraps naturally
         if (w_frame_done) begin
            r_seq <= r_seq + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_tx_valid  = 1'b0;
      w_tx_data   = 8'h00;
      w_tx_last   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pop) w_state_nxt = S_HDR;
         end
         S_HDR: begin
            w_tx_valid = 1'b1;
            w_tx_data  = r_fail ? HDR_FAIL : HDR_OK;
            if (tx_ready) w_state_nxt = S_SEQ;
         end
         S_SEQ: begin
            w_tx_valid = 1'b1;
            w_tx_data  = r_seq;
            w_tx_last  = r_fail;
            if (tx_ready) w_state_nxt = r_fail ? S_IDLE : S_BODY;
         end
         S_BODY: begin
            w_tx_valid = 1'b1;
            w_tx_data  = r_shift[127:120];
            w_tx_last  = (r_cnt == 4'd0);
            if (tx_ready && r_cnt == 4'd0) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign tx_valid = w_tx_valid;
   assign tx_data  = w_tx_data;
   assign tx_last  = w_tx_last;
   assign busy     = (r_state != S_IDLE) || (r_count != '0);
   assign overflow = r_overflow;
   assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_result_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mips_result_serializer
// Description : Self-checking bench for mips_result_serializer. Directed
//               frame vectors plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_result_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_fail;
   logic [31:0] in_data_1, in_data_2, in_data_3, in_data_4;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_last;
   logic        busy;
   logic        overflow;
   logic [7:0]  drop_cnt;

   int errors = 0;
   int checks = 0;

   logic [7:0] rx_q[$];
   logic       rx_last_q[$];
   logic [7:0] exp_q[$];

   typedef struct {
      logic        fail;
      logic [31:0] d1, d2, d3, d4;
      bit          toggle;
      logic [7:0]  seq;
   } vec_t;

   vec_t vecs[4];

   logic [7:0] ok_bytes[18] = '{8'hA5, 8'h00,
                                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

   mips_result_serializer #(
      .FIFO_DEPTH (4),
      .HDR_OK     (8'hA5),
      .HDR_FAIL   (8'hEE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_fail   (in_fail),
      .in_data_1 (in_data_1),
      .in_data_2 (in_data_2),
      .in_data_3 (in_data_3),
      .in_data_4 (in_data_4),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_last   (tx_last),
      .busy      (busy),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic send(input logic f, input logic [31:0] a, b, c, d);
      in_valid  = 1'b1;
      in_fail   = f;
      in_data_1 = a;
      in_data_2 = b;
      in_data_3 = c;
      in_data_4 = d;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_fail   = 1'b0;
   endtask

   task automatic build_exp(input logic f, input logic [31:0] a, b, c, d, input logic [7:0] s);
      logic [127:0] body;
      exp_q.delete();
      exp_q.push_back(f ? 8'hEE : 8'hA5);
      exp_q.push_back(s);
      if (!f) begin
         body = {a, b, c, d};
         for (int i = 0; i < 16; i++) exp_q.push_back(body[127 - 8*i -: 8]);
      end
   endtask

   // Collects one frame; with toggle the consumer alternates ready 1/0 and
   // every stalled byte must still be presented unchanged next cycle.
   task automatic recv_frame(input bit toggle, input int max_cyc);
      int         cyc  = 0;
      bit         done = 0;
      bit         hold = 0;
      logic [7:0] hd   = 8'h00;
      logic       hl   = 1'b0;
      rx_q.delete();
      rx_last_q.delete();
      while (!done && cyc < max_cyc) begin
         tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (hold) begin
            chk("stall_valid", {31'd0, tx_valid}, 32'd1);
            chk("stall_data", {24'd0, tx_data}, {24'd0, hd});
            chk("stall_last", {31'd0, tx_last}, {31'd0, hl});
            hold = 0;
         end
         if (tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            rx_last_q.push_back(tx_last);
            if (tx_last) done = 1;
         end else if (tx_valid) begin
            hold = 1;
            hd   = tx_data;
            hl   = tx_last;
         end
         @(posedge clk); #1;
         cyc++;
      end
      tx_ready = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL recv_timeout: got %0d bytes expected a complete frame", rx_q.size());
      end
   endtask

   task automatic cmp_frame();
      chk("frame_len", rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         chk("frame_byte", {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
         chk("frame_last", {31'd0, rx_last_q[i]}, (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 1'b0, 8'h01};
      vecs[1] = '{1'b0, 32'h11223344, 32'h55667788, 32'h00000000, 32'hFFFFFFFF, 1'b1, 8'h02};
      vecs[2] = '{1'b0, 32'h01020304, 32'hA0B0C0D0, 32'h00000000, 32'h80000001, 1'b1, 8'h03};
      vecs[3] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b1, 8'h04};

      in_valid = 0; in_fail = 0; tx_ready = 0;
      in_data_1 = 0; in_data_2 = 0; in_data_3 = 0; in_data_4 = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_tx_last", {31'd0, tx_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // OK frame with latency: header appears two edges after the strobe
      send(1'b0, 32'h11223344, 32'h55667788, 32'h00000000, 32'hFFFFFFFF);
      chk("lat_e_valid", {31'd0, tx_valid}, 32'd0);
      chk("lat_e_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("lat_e1_valid", {31'd0, tx_valid}, 32'd1);
      chk("lat_e1_data", {24'd0, tx_data}, 32'hA5);
      recv_frame(1'b0, 40);
      exp_q.delete();
      for (int i = 0; i < 18; i++) exp_q.push_back(ok_bytes[i]);
      cmp_frame();
      chk("ok_busy_after", {31'd0, busy}, 32'd0);

      // Table-driven frames (fail, back-pressure, mixed)
      for (int v = 0; v < 4; v++) begin
         send(vecs[v].fail, vecs[v].d1, vecs[v].d2, vecs[v].d3, vecs[v].d4);
         recv_frame(vecs[v].toggle, 80);
         build_exp(vecs[v].fail, vecs[v].d1, vecs[v].d2, vecs[v].d3, vecs[v].d4, vecs[v].seq);
         cmp_frame();
         chk("vec_busy_after", {31'd0, busy}, 32'd0);
      end

      // Overflow: 6 consecutive strobes with the consumer stalled
      do_reset();
      tx_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_fail   = 1'b0;
         in_data_1 = 32'(i);
         in_data_2 = 32'h100 + 32'(i);
         in_data_3 = 32'h200 + 32'(i);
         in_data_4 = 32'h300 + 32'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("ovf_overflow", {31'd0, overflow}, 32'd1);
      chk("ovf_drop_cnt", {24'd0, drop_cnt}, 32'd1);
      chk("ovf_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         recv_frame(1'b0, 40);
         build_exp(1'b0, 32'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i), 8'(i));
         cmp_frame();
      end
      chk("ovf_busy_end", {31'd0, busy}, 32'd0);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);
      chk("ovf_drop_sticky", {24'd0, drop_cnt}, 32'd1);

      // Seq wrap over 257 fail frames
      do_reset();
      for (int i = 0; i < 257; i++) begin
         send(1'b1, 32'(i), 32'h0, 32'h0, 32'h0);
         recv_frame(1'b0, 20);
         build_exp(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 8'(i));
         cmp_frame();
      end

      // Reset mid-frame with bundles queued and a drop recorded
      do_reset();
      tx_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data_1 = 32'hAAAA0000 + 32'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      tx_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_in_body_valid", {31'd0, tx_valid}, 32'd1);
      chk("mid_in_body_last", {31'd0, tx_last}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
      chk("mid_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      begin
         int seen = 0;
         for (int i = 0; i < 10; i++) begin
            if (tx_valid) seen++;
            @(posedge clk); #1;
         end
         chk("post_rst_quiet", 32'(seen), 32'd0);
      end
      send(1'b0, 32'h0BADF00D, 32'h13572468, 32'h00FF00FF, 32'h76543210);
      recv_frame(1'b0, 40);
      build_exp(1'b0, 32'h0BADF00D, 32'h13572468, 32'h00FF00FF, 32'h76543210, 8'h00);
      cmp_frame();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
